// File: rtl/cp0_exc_unit_if.sv
// CP0 / exception unit bus: write-back instruction info, CP0 moves,
// hardware interrupts in; read data and front-end redirect out.
interface cp0_exc_unit_if #(
    parameter int unsigned N_HWINT = 6
);
    logic                wb_valid;
    logic [31:0]         pc;
    logic [31:0]         bad_vaddr;
    logic                fetch_error;
    logic                raddr_error;
    logic                waddr_error;
    logic                overflow;
    logic                syscall;
    logic                eret;
    logic                mtc0;
    logic                mfc0;
    logic [7:0]          cp0_addr;
    logic [31:0]         cp0_wdata;
    logic [N_HWINT-1:0]  hw_int;
    logic [31:0]         cp0_rdata;
    logic                exc_valid;
    logic [31:0]         exc_pc;
    logic                cancel;
    logic                int_pending;

    modport master (
        output wb_valid, pc, bad_vaddr, fetch_error, raddr_error, waddr_error,
               overflow, syscall, eret, mtc0, mfc0, cp0_addr, cp0_wdata, hw_int,
        input  cp0_rdata, exc_valid, exc_pc, cancel, int_pending
    );

    modport slave (
        input  wb_valid, pc, bad_vaddr, fetch_error, raddr_error, waddr_error,
               overflow, syscall, eret, mtc0, mfc0, cp0_addr, cp0_wdata, hw_int,
        output cp0_rdata, exc_valid, exc_pc, cancel, int_pending
    );
endinterface

// File: rtl/cp0_exc_unit.sv
// CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC) with
// exception/interrupt prioritisation and ERET handling at write-back.
// N_HWINT must match the N_HWINT of the connected interface instance.
module cp0_exc_unit #(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_0000,
    parameter int unsigned N_HWINT   = 6,
    parameter int unsigned COUNT_DIV = 2
) (
    input logic            clk,
    input logic            resetn,
    cp0_exc_unit_if.slave  bus
);
    localparam logic [7:0] A_BADVADDR = 8'h40;  // {8,0}
    localparam logic [7:0] A_COUNT    = 8'h48;  // {9,0}
    localparam logic [7:0] A_COMPARE  = 8'h58;  // {11,0}
    localparam logic [7:0] A_STATUS   = 8'h60;  // {12,0}
    localparam logic [7:0] A_CAUSE    = 8'h68;  // {13,0}
    localparam logic [7:0] A_EPC      = 8'h70;  // {14,0}
    localparam logic [3:0] DIV_MAX    = 4'(COUNT_DIV - 1);

    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] epc;
    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic        ti;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code;
    logic [3:0]  div_cnt;

    logic [5:0]  hw_in;
    logic [7:0]  ip;
    logic        int_pend;
    logic        exc_take;
    logic [4:0]  code_nxt;
    logic        bv_we;
    logic [31:0] bv_val;
    logic        eret_take;
    logic        mtc0_we;
    logic        tick;
    logic        count_wr;
    logic [31:0] count_inc;
    logic        unused_mfc0;

    assign unused_mfc0 = bus.mfc0;

    // Unused hardware interrupt lines read as constant 0.
    for (genvar g = 0; g < 6; g++) begin : g_hwin
        if (g < N_HWINT) begin : g_used
            assign hw_in[g] = bus.hw_int[g];
        end else begin : g_unused
            assign hw_in[g] = 1'b0;
        end
    end

    assign ip        = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
    assign int_pend  = ie & ~exl & (|(ip & im));
    assign tick      = (div_cnt == DIV_MAX);
    assign count_inc = count + 32'd1;

    // Exception priority encoder; BadVAddr source follows the winning cause.
    always_comb begin
        exc_take = 1'b0;
        code_nxt = 5'd0;
        bv_we    = 1'b0;
        bv_val   = '0;
        if (resetn && bus.wb_valid) begin
            if (int_pend) begin
                exc_take = 1'b1;
                code_nxt = 5'd0;
            end else if (bus.fetch_error) begin
                exc_take = 1'b1;
                code_nxt = 5'd4;
                bv_we    = 1'b1;
                bv_val   = bus.pc;
            end else if (bus.overflow) begin
                exc_take = 1'b1;
                code_nxt = 5'd12;
            end else if (bus.syscall) begin
                exc_take = 1'b1;
                code_nxt = 5'd8;
            end else if (bus.raddr_error) begin
                exc_take = 1'b1;
                code_nxt = 5'd4;
                bv_we    = 1'b1;
                bv_val   = bus.bad_vaddr;
            end else if (bus.waddr_error) begin
                exc_take = 1'b1;
                code_nxt = 5'd5;
                bv_we    = 1'b1;
                bv_val   = bus.bad_vaddr;
            end
        end
    end

    assign eret_take = resetn & bus.wb_valid & bus.eret & ~exc_take;
    assign mtc0_we   = resetn & bus.wb_valid & bus.mtc0 & ~exc_take;
    assign count_wr  = mtc0_we & (bus.cp0_addr == A_COUNT);

    assign bus.exc_valid   = exc_take | eret_take;
    assign bus.cancel      = exc_take | eret_take;
    assign bus.exc_pc      = eret_take ? epc : EXC_ENTRY;
    assign bus.int_pending = int_pend;

    // Combinational CP0 read of the pre-edge register values.
    always_comb begin
        bus.cp0_rdata = '0;
        case (bus.cp0_addr)
            A_BADVADDR: bus.cp0_rdata = badvaddr;
            A_COUNT:    bus.cp0_rdata = count;
            A_COMPARE:  bus.cp0_rdata = compare;
            A_STATUS:   bus.cp0_rdata = {16'h0, im, 6'h0, exl, ie};
            A_CAUSE:    bus.cp0_rdata = {1'b0, ti, 14'h0, ip, 1'b0, exc_code, 2'b00};
            A_EPC:      bus.cp0_rdata = epc;
            default:    bus.cp0_rdata = '0;
        endcase
    end

    // CP0 state: timer, interrupt sampling, exception entry/return, mtc0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            badvaddr <= '0;
            count    <= '0;
            compare  <= '0;
            epc      <= '0;
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            ti       <= 1'b0;
            ip_hw    <= '0;
            ip_sw    <= '0;
            exc_code <= '0;
            div_cnt  <= '0;
        end else begin
            ip_hw <= hw_in;

            if (count_wr) begin
                count   <= bus.cp0_wdata;
                div_cnt <= '0;
            end else if (tick) begin
                count   <= count_inc;
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 4'd1;
            end

            if (mtc0_we && bus.cp0_addr == A_COMPARE) begin
                compare <= bus.cp0_wdata;
                ti      <= 1'b0;
            end else if (tick && !count_wr && count_inc == compare) begin
                ti <= 1'b1;
            end

            if (exc_take) begin
                exl      <= 1'b1;
                exc_code <= code_nxt;
                if (!exl) epc <= bus.pc;
                if (bv_we) badvaddr <= bv_val;
            end else begin
                if (mtc0_we) begin
                    case (bus.cp0_addr)
                        A_STATUS: begin
                            im  <= bus.cp0_wdata[15:8];
                            exl <= bus.cp0_wdata[1];
                            ie  <= bus.cp0_wdata[0];
                        end
                        A_CAUSE: ip_sw <= bus.cp0_wdata[9:8];
                        A_EPC:   epc   <= bus.cp0_wdata;
                        default: ;
                    endcase
                end
                if (eret_take) exl <= 1'b0;
            end
        end
    end
endmodule

// File: doc/cp0_exc_unit.md
CP0_EXC_UNIT -- requirements
Module: cp0_exc_unit

Interface
REQ-001 SHALL have parameter EXC_ENTRY, default 32'h0000_0000: PC driven on exc_pc for every exception and interrupt entry.
REQ-002 SHALL have parameter N_HWINT, default 6, legal 1..6: number of hardware interrupt lines.
REQ-003 SHALL have parameter COUNT_DIV, default 2, legal 1..16: clock cycles per Count increment.
REQ-004 Ports, in order:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- wb_valid  in  1  instruction in WB is valid.
- pc  in  32  PC of the WB instruction.
- bad_vaddr  in  32  data address of a faulting load/store.
- fetch_error, raddr_error, waddr_error, overflow, syscall, eret  in  1 each  exception/return flags of the WB instruction.
- mtc0, mfc0  in  1 each  CP0 move strobes.
- cp0_addr  in  8  {reg[4:0], sel[2:0]}.
- cp0_wdata  in  32  mtc0 data.
- hw_int  in  N_HWINT  level hardware interrupts.
- cp0_rdata  out  32  mfc0 read data.
- exc_valid  out  1  redirect the front end.
- exc_pc  out  32  redirect target.
- cancel  out  1  flush younger instructions.
- int_pending  out  1  a qualified interrupt is pending.
REQ-005 SHALL run on the single clock clk; reset is asynchronous and active-low (resetn); the polarity and synchronicity are fixed.

Function
REQ-006 SHALL implement BadVAddr {8,0}, Count {9,0}, Compare {11,0}, Status {12,0}, Cause {13,0} and EPC {14,0}; any other address reads 0 and ignores writes.
REQ-007 Status SHALL hold IM[15:8] (R/W), EXL[1] (R/W) and IE[0] (R/W); all other bits read 0.
REQ-008 Cause SHALL hold TI[30] (RO), IP[15:10] (RO, hardware), IP[9:8] (R/W, software) and ExcCode[6:2] (RO); all other bits read 0.
REQ-009 IP[10+i] SHALL be hw_int[i] registered once per cycle for i<N_HWINT, and 0 for unused bits; IP[15] is additionally ORed with TI.
REQ-010 The Count divider SHALL increment Count by 1 (mod 2^32) every COUNT_DIV cycles; with COUNT_DIV=1 it increments every cycle.
REQ-011 mtc0 to Count SHALL load cp0_wdata and restart the divider.
REQ-012 TI SHALL be set on the edge where an increment makes Count equal to Compare; mtc0 to Compare SHALL load the value and clear TI in the same edge.
REQ-013 int_pending SHALL equal IE & ~EXL & |(IP[15:8] & IM[15:8]), and SHALL be combinational.
REQ-014 A WB event SHALL be qualified by wb_valid; with wb_valid=0 no register changes except Count, TI and hardware IP.
REQ-015 Priority, highest first, with ExcCode:
- interrupt (int_pending), 0
- fetch_error, 4, BadVAddr<=pc
- overflow, 12
- syscall, 8
- raddr_error, 4, BadVAddr<=bad_vaddr
- waddr_error, 5, BadVAddr<=bad_vaddr
REQ-016 On a taken exception, exc_valid=1 and exc_pc=EXC_ENTRY combinationally in the same cycle; at the next edge EXL<=1, ExcCode is written, and EPC<=pc only if EXL was 0 before.
REQ-017 eret with no exception in the same cycle SHALL give exc_valid=1 and exc_pc=EPC, and clear EXL at the next edge.
REQ-018 cancel SHALL equal exc_valid.
REQ-019 When an exception and mtc0 occur in the same cycle, the exception wins and the mtc0 write is suppressed.
REQ-020 When mtc0 writes Status, Cause or EPC in a non-exception cycle, the write SHALL take effect at the next edge.
REQ-021 cp0_rdata SHALL be a combinational read of cp0_addr, showing the pre-edge value; it is valid regardless of the mfc0 level.
REQ-022 A Count increment and an mtc0 to Count in the same cycle: the mtc0 value wins.

Reset
REQ-023 While resetn=0, every CP0 register and the divider SHALL be 0; exc_valid, cancel and int_pending are 0, and exc_pc is EXC_ENTRY.
REQ-024 Reset asserted mid-operation SHALL clear state immediately, with no wait for clk; Count resumes from 0 after release.

Verification
REQ-025 mtc0 Compare=5, COUNT_DIV=2, IE=1, IM[7]=1 -> TI=1 after 10 cycles; int_pending=1; next valid instruction exc_pc=0, ExcCode=0, EPC=its pc.
REQ-026 syscall at pc=0x100 with EXL=0 -> exc_valid=1 same cycle; next cycle Cause[6:2]=8, EPC=0x100, Status=0x2; then eret -> exc_pc=0x100, EXL=0.
REQ-027 raddr_error, bad_vaddr=0x1003, pc=0x200 -> BadVAddr=0x1003, ExcCode=4; fetch_error with overflow together -> ExcCode=4, BadVAddr=pc.
REQ-028 Exception with EXL=1, EPC=0x100, pc=0x300 -> EPC stays 0x100; mtc0 EPC in the same cycle as overflow -> EPC not written.
REQ-029 N_HWINT=2, hw_int=2'b10, IM=0x08, IE=1 -> Cause=0x0800 one cycle later, int_pending=1; IE=0 -> int_pending=0.
REQ-030 resetn pulsed low between edges with Count=0x1234 -> Count=0 immediately, outputs at reset values.
